// File: rtl/sm_debug_ctrl_pkg.sv
// Shared constants and types for the board-level debug sequencer.
// Default timing values assume a 50 MHz board clock.
package sm_debug_ctrl_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;   // 10 ms key settle time
    localparam int unsigned DEF_STEP_CYCLES     = 16;       // clock-enable burst per step
    localparam int unsigned DEF_SCAN_DWELL      = 25000000; // cycles per displayed address
    localparam int unsigned DEF_READ_LAT        = 2;        // regAddr -> regData latency

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_STEP = 1'b1
    } step_state_t;

    typedef enum logic [1:0] {
        SC_ADDR  = 2'd0,
        SC_WAIT  = 2'd1,
        SC_CAPT  = 2'd2,
        SC_DWELL = 2'd3
    } scan_state_t;

    // Register index after a; 31 wraps to 0 through the natural 5-bit overflow.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sm_debug_ctrl_if.sv
// Register-file debug port and display capture bundle between the
// debug sequencer (master) and sm_top / display logic (slave).
interface sm_debug_ctrl_if;
    import sm_debug_ctrl_pkg::*;

    logic [ADDR_W-1:0] reg_addr;    // register index presented to sm_top
    logic [DATA_W-1:0] reg_data;    // read data returned by sm_top
    logic [DATA_W-1:0] disp_data;   // captured value for HEX/LEDR
    logic [ADDR_W-1:0] disp_addr;   // index that disp_data belongs to
    logic              disp_valid;  // one-cycle strobe on each capture

    modport master (
        output reg_addr,
        output disp_data,
        output disp_addr,
        output disp_valid,
        input  reg_data
    );

    modport slave (
        input  reg_addr,
        input  disp_data,
        input  disp_addr,
        input  disp_valid,
        output reg_data
    );

endinterface

// File: rtl/sm_debug_ctrl_debouncer.sv
// Step-key conditioning: two-flop synchroniser, settle counter and a
// single-cycle press pulse on the falling edge of the debounced level.
// The debounced level idles high (key released) out of reset so a key
// that is already up never produces a spurious press.
module sm_debug_ctrl_debouncer
    import sm_debug_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_settle;

    // Synchronise the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // A sample equal to the current level restarts the count, so the
    // level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    assign w_differs = (r_sync2 != r_level);
    assign w_settle  = w_differs && (r_cnt == CNT_LAST);

    // Settle counter and debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (!w_differs) begin
            r_cnt   <= '0;
        end else if (w_settle) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Pulse in the cycle the level is about to fall, so the step FSM
    // reacts on the same edge that commits the debounced press.
    assign o_press = w_settle && r_level;

endmodule

// File: rtl/sm_debug_ctrl.sv
// Board-level debug sequencer between the DE1-SoC pins and sm_top.
// Produces single-step clock-enable bursts from the step key, a free-run
// override, and a register-file scan that captures read data for display.
//
// Step FSM
//   state  | meaning
//   S_IDLE | clock enable low unless free-run; waiting for a press
//   S_STEP | clock enable high for STEP_CYCLES cycles
//
// Scan FSM (one full rotation is exactly SCAN_DWELL cycles)
//   state    | meaning
//   SC_ADDR  | load reg_addr with the next scan index or the held index
//   SC_WAIT  | READ_LAT cycles for the register file to respond
//   SC_CAPT  | capture reg_data/reg_addr into the display registers
//   SC_DWELL | pad the period out to SCAN_DWELL cycles
//
// Constraints: READ_LAT >= 1, SCAN_DWELL >= READ_LAT + 2.
module sm_debug_ctrl
    import sm_debug_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STEP_CYCLES     = DEF_STEP_CYCLES,
    parameter int unsigned SCAN_DWELL      = DEF_SCAN_DWELL,
    parameter int unsigned READ_LAT        = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_step_key_n,
    input  logic              i_run_sw,
    input  logic              i_scan_en,
    input  logic [ADDR_W-1:0] i_hold_addr,
    output logic              o_clk_enable,
    sm_debug_ctrl_if.master   dbg
);

    localparam int unsigned         STEP_W    = $clog2(STEP_CYCLES + 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    localparam int unsigned         DWELL_PAD = SCAN_DWELL - READ_LAT - 2;
    localparam int unsigned         SCAN_W    = $clog2(SCAN_DWELL + 1);
    localparam logic [SCAN_W-1:0]   WAIT_LAST = SCAN_W'(READ_LAT - 1);
    localparam logic [SCAN_W-1:0]   PAD_LAST  = SCAN_W'((DWELL_PAD == 0) ? 0 : DWELL_PAD - 1);

    logic              w_step_req;
    logic              r_run_s1;
    logic              r_run_s2;

    step_state_t       r_step_state;
    step_state_t       w_step_state_nxt;
    logic [STEP_W-1:0] r_step_cnt;
    logic [STEP_W-1:0] w_step_cnt_nxt;
    logic              r_clk_en;

    scan_state_t       r_scan_state;
    scan_state_t       w_scan_state_nxt;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [SCAN_W-1:0] w_scan_cnt_nxt;
    logic              r_first;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [DATA_W-1:0] r_disp_data;
    logic [ADDR_W-1:0] r_disp_addr;
    logic              r_disp_valid;

    sm_debug_ctrl_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (i_step_key_n),
        .o_press (w_step_req)
    );

    // Synchronise the free-run switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_s1 <= 1'b0;
            r_run_s2 <= 1'b0;
        end else begin
            r_run_s1 <= i_run_sw;
            r_run_s2 <= r_run_s1;
        end
    end

    // Step FSM registers; clock enable is registered from the next state
    // so a burst starts on the same edge that accepts the press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_state <= S_IDLE;
            r_step_cnt   <= '0;
            r_clk_en     <= 1'b0;
        end else begin
            r_step_state <= w_step_state_nxt;
            r_step_cnt   <= w_step_cnt_nxt;
            r_clk_en     <= r_run_s2 || (w_step_state_nxt == S_STEP);
        end
    end

    // Step FSM next state; presses during a burst or in free-run are dropped.
    always_comb begin
        w_step_state_nxt = r_step_state;
        w_step_cnt_nxt   = r_step_cnt;
        case (r_step_state)
            S_IDLE: begin
                w_step_cnt_nxt = '0;
                if (w_step_req && !r_run_s2) begin
                    w_step_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (r_run_s2 || (r_step_cnt == STEP_LAST)) begin
                    w_step_state_nxt = S_IDLE;
                    w_step_cnt_nxt   = '0;
                end else begin
                    w_step_cnt_nxt   = r_step_cnt + STEP_W'(1);
                end
            end
            default: begin
                w_step_state_nxt = S_IDLE;
                w_step_cnt_nxt   = '0;
            end
        endcase
    end

    // Scan FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_state <= SC_ADDR;
            r_scan_cnt   <= '0;
        end else begin
            r_scan_state <= w_scan_state_nxt;
            r_scan_cnt   <= w_scan_cnt_nxt;
        end
    end

    // Scan FSM next state; the counter is shared by WAIT and DWELL.
    always_comb begin
        w_scan_state_nxt = r_scan_state;
        w_scan_cnt_nxt   = r_scan_cnt;
        case (r_scan_state)
            SC_ADDR: begin
                w_scan_state_nxt = SC_WAIT;
                w_scan_cnt_nxt   = '0;
            end
            SC_WAIT: begin
                if (r_scan_cnt == WAIT_LAST) begin
                    w_scan_state_nxt = SC_CAPT;
                    w_scan_cnt_nxt   = '0;
                end else begin
                    w_scan_cnt_nxt   = r_scan_cnt + SCAN_W'(1);
                end
            end
            SC_CAPT: begin
                w_scan_cnt_nxt = '0;
                if (DWELL_PAD == 0) begin
                    w_scan_state_nxt = SC_ADDR;
                end else begin
                    w_scan_state_nxt = SC_DWELL;
                end
            end
            SC_DWELL: begin
                if (r_scan_cnt == PAD_LAST) begin
                    w_scan_state_nxt = SC_ADDR;
                    w_scan_cnt_nxt   = '0;
                end else begin
                    w_scan_cnt_nxt   = r_scan_cnt + SCAN_W'(1);
                end
            end
            default: begin
                w_scan_state_nxt = SC_ADDR;
                w_scan_cnt_nxt   = '0;
            end
        endcase
    end

    // Address selection and display capture. Switches are only looked at in
    // SC_ADDR, so reg_addr is stable from SC_WAIT through SC_CAPT. Leaving
    // reg_addr at the held index makes a later scan resume at hold + 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first      <= 1'b1;
            r_reg_addr   <= '0;
            r_disp_data  <= '0;
            r_disp_addr  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_disp_valid <= 1'b0;
            if (r_scan_state == SC_ADDR) begin
                r_first <= 1'b0;
                if (i_scan_en) begin
                    r_reg_addr <= r_first ? '0 : next_addr(r_reg_addr);
                end else begin
                    r_reg_addr <= i_hold_addr;
                end
            end
            if (r_scan_state == SC_CAPT) begin
                r_disp_data  <= dbg.reg_data;
                r_disp_addr  <= r_reg_addr;
                r_disp_valid <= 1'b1;
            end
        end
    end

    assign o_clk_enable   = r_clk_en;
    assign dbg.reg_addr   = r_reg_addr;
    assign dbg.disp_data  = r_disp_data;
    assign dbg.disp_addr  = r_disp_addr;
    assign dbg.disp_valid = r_disp_valid;

endmodule
